// File: rtl/rev_seqckt_if.sv
// Serial-delay signal bundle: input sample plus delayed output, taps, edge pulses and fill flag.
interface rev_seqckt_if #(
  parameter int DEPTH = 1
);
  logic             d_in;
  logic             d_out;
  logic [DEPTH-1:0] taps;
  logic             rise;
  logic             fall;
  logic             primed;

  modport master (
    output d_in,
    input  d_out, taps, rise, fall, primed
  );

  modport slave (
    input  d_in,
    output d_out, taps, rise, fall, primed
  );
endinterface

// File: rtl/rev_seqckt.sv
// Single-bit retiming delay line with taps, registered edge pulses and fill indicator.
// Latency DEPTH edges from d_in to d_out; free-running, no backpressure.
module rev_seqckt #(
  parameter int   DEPTH     = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input logic          clk,
  input logic          rst,
  rev_seqckt_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] stage;
  logic             hist;
  logic [CW-1:0]    fill_cnt;

  // stage[0] holds the newest sample, so the vector shifts toward the MSB.
  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage <= RESET_VAL;
      end else begin
        stage <= bus.d_in;
      end
    end
  end else begin : g_chain
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage <= {DEPTH{RESET_VAL}};
      end else begin
        stage <= {stage[DEPTH-2:0], bus.d_in};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= RESET_VAL;
    end else begin
      hist <= stage[DEPTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (fill_cnt != CW'(DEPTH)) begin
      fill_cnt <= fill_cnt + CW'(1);
    end
  end

  assign bus.d_out  = stage[DEPTH-1];
  assign bus.taps   = stage;
  assign bus.rise   = stage[DEPTH-1] & ~hist;
  assign bus.fall   = ~stage[DEPTH-1] & hist;
  assign bus.primed = (fill_cnt == CW'(DEPTH));
endmodule

// File: tb/tb_rev_seqckt.sv
// Scoreboard bench for rev_seqckt across four depth/reset-value configurations.
module tb_rev_seqckt;
  logic clk = 1'b0;
  logic r1, r4, r4h, r2;

  rev_seqckt_if #(.DEPTH(1)) b1 ();
  rev_seqckt_if #(.DEPTH(4)) b4 ();
  rev_seqckt_if #(.DEPTH(4)) b4h ();
  rev_seqckt_if #(.DEPTH(2)) b2 ();

  rev_seqckt #(.DEPTH(1), .RESET_VAL(1'b0)) u1  (.clk(clk), .rst(r1),  .bus(b1));
  rev_seqckt #(.DEPTH(4), .RESET_VAL(1'b0)) u4  (.clk(clk), .rst(r4),  .bus(b4));
  rev_seqckt #(.DEPTH(4), .RESET_VAL(1'b1)) u4h (.clk(clk), .rst(r4h), .bus(b4h));
  rev_seqckt #(.DEPTH(2), .RESET_VAL(1'b0)) u2  (.clk(clk), .rst(r2),  .bus(b2));

  always #5 clk = ~clk;

  typedef struct {
    int         dut;
    string      name;
    int         at_edge;
    logic [7:0] want;   // {d_out, taps[3:0], rise, fall, primed}
  } exp_t;

  exp_t q[$];
  int   edge_cnt    = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  event mid_ev;

  function automatic logic [7:0] actual(int dut);
    case (dut)
      0:       return {b1.d_out,  3'b000, b1.taps,  b1.rise,  b1.fall,  b1.primed};
      1:       return {b4.d_out,  b4.taps,           b4.rise,  b4.fall,  b4.primed};
      2:       return {b4h.d_out, b4h.taps,          b4h.rise, b4h.fall, b4h.primed};
      default: return {b2.d_out,  2'b00,  b2.taps,  b2.rise,  b2.fall,  b2.primed};
    endcase
  endfunction

  task automatic drive(int dut, logic v);
    case (dut)
      0:       b1.d_in  = v;
      1:       b4.d_in  = v;
      2:       b4h.d_in = v;
      default: b2.d_in  = v;
    endcase
  endtask

  task automatic set_rst(int dut, logic v);
    case (dut)
      0:       r1  = v;
      1:       r4  = v;
      2:       r4h = v;
      default: r2  = v;
    endcase
  endtask

  task automatic expect_at(int dut, string name, int at_edge, logic d_out,
                           logic [3:0] taps, logic rise, logic fall, logic primed);
    exp_t e;
    e.dut     = dut;
    e.name    = name;
    e.at_edge = at_edge;
    e.want    = {d_out, taps, rise, fall, primed};
    q.push_back(e);
  endtask

  // Drive one sample between edges and queue the state expected right after the next edge.
  task automatic step(int dut, string name, bit rel, logic din, logic d_out,
                      logic [3:0] taps, logic rise, logic fall, logic primed);
    @(negedge clk);
    drive(dut, din);
    if (rel) set_rst(dut, 1'b0);
    expect_at(dut, name, edge_cnt + 1, d_out, taps, rise, fall, primed);
  endtask

  task automatic drain();
    int i = 0;
    while (i < q.size()) begin
      if (q[i].at_edge <= edge_cnt) begin
        logic [7:0] got;
        got = actual(q[i].dut);
        vectors++;
        if (got !== q[i].want) begin
          miscompares++;
          $display("FAIL %s: got %b want %b (d_out,taps[3:0],rise,fall,primed)",
                   q[i].name, got, q[i].want);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      drain();
    end
  end

  initial begin
    forever begin
      @(mid_ev);
      drain();
    end
  end

  initial begin
    r1 = 1'b1; r4 = 1'b1; r4h = 1'b1; r2 = 1'b1;
    b1.d_in = 1'b0; b4.d_in = 1'b0; b4h.d_in = 1'b0; b2.d_in = 1'b0;
    #1;
    expect_at(0, "rst_d1",     edge_cnt, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    expect_at(1, "rst_d4",     edge_cnt, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    expect_at(2, "rst_d4_rv1", edge_cnt, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(3, "rst_d2",     edge_cnt, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    ->mid_ev;

    // DEPTH=1: plain flop behaviour with edge pulses.
    step(0, "d1_e1", 1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    step(0, "d1_e2", 0, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1);
    step(0, "d1_e3", 0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    step(0, "d1_e4", 0, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle while d_out is high.
    @(posedge clk);
    #2 set_rst(0, 1'b1);
    #1;
    expect_at(0, "d1_async_rst", edge_cnt, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    ->mid_ev;
    #1 set_rst(0, 1'b0);
    step(0, "d1_after_rst", 0, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1);

    // Alternating input: rise and fall alternate every cycle.
    for (int k = 0; k < 6; k++) begin
      logic v;
      v = (k % 2 == 1);
      step(0, $sformatf("d1_alt%0d", k), 0, v, v, {3'b000, v}, v, ~v, 1'b1);
    end

    // DEPTH=4: pattern 1,0,0,1,1 then zeros.
    step(1, "d4_e1", 1, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(1, "d4_e2", 0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    step(1, "d4_e3", 0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
    step(1, "d4_e4", 0, 1'b1, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b1);
    step(1, "d4_e5", 0, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b1, 1'b1);
    step(1, "d4_e6", 0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b1);
    step(1, "d4_e7", 0, 1'b0, 1'b1, 4'b1100, 1'b1, 1'b0, 1'b1);
    step(1, "d4_e8", 0, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1);
    step(1, "d4_e9", 0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);

    // DEPTH=4, RESET_VAL=1, constant zero in: single fall pulse.
    step(2, "d4h_e1", 1, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);
    step(2, "d4h_e2", 0, 1'b0, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0);
    step(2, "d4h_e3", 0, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
    step(2, "d4h_e4", 0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    step(2, "d4h_e5", 0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    step(2, "d4h_e6", 0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

    // DEPTH=2, constant one for 8 edges: exactly one rise.
    step(3, "d2_e1", 1, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(3, "d2_e2", 0, 1'b1, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b1);
    for (int k = 3; k <= 8; k++) begin
      step(3, $sformatf("d2_e%0d", k), 0, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b1);
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
      miscompares += q.size();
      vectors += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
